mod_fifo_sched: RTL

- Controller in front of, and behind, the 8-deep synchronous bit FIFO that feeds the sine-wave modulator.
- Shares the FIFO write port between two serial bit requesters, using round-robin arbitration per frame.
- Sequences FIFO reads so that one bit is popped per modulator symbol-done flag.
- Holds off reading until a prefill level is reached, and counts underruns.

---
 rtl/mod_fifo_sched_pkg.sv | 26 ++
 rtl/mod_fifo_sched_rr_arb2.sv | 44 ++++
 rtl/mod_fifo_sched.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mod_fifo_sched_pkg.sv
// Shared encodings and width helpers for the modulator FIFO scheduler.
package mod_sched_pkg;

  // Write-side FSM: waiting for a requester, or moving a frame into the FIFO.
  typedef enum logic {
    W_IDLE = 1'b0,
    W_XFER = 1'b1
  } w_state_e;

  // Read-side FSM: waiting for prefill, or popping one bit per symbol.
  typedef enum logic {
    R_FILL = 1'b0,
    R_RUN  = 1'b1
  } r_state_e;

  // Occupancy must be able to hold the value DEPTH itself.
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Frame bit counter width, never narrower than one bit.
  function automatic int bcnt_w(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

endpackage

// File: rtl/mod_fifo_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester to try first.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic [1:0] winner,
  output logic [1:0] pick
);

  // prio_q = 0 prefers requester 0, prio_q = 1 prefers requester 1.
  logic prio_q, prio_d;

  // After a completed frame, the requester that did not win gets preference.
  always_comb begin
    prio_d = prio_q;
    if (update) begin
      if (winner[0]) begin
        prio_d = 1'b1;
      end else if (winner[1]) begin
        prio_d = 1'b0;
      end
    end
  end

  // One-hot pick: preferred requester if valid, otherwise the other one.
  always_comb begin
    pick = 2'b00;
    if (!prio_q) begin
      if (req[0])      pick = 2'b01;
      else if (req[1]) pick = 2'b10;
    end else begin
      if (req[1])      pick = 2'b10;
      else if (req[0]) pick = 2'b01;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/mod_fifo_sched.sv
// Write-port arbiter and read sequencer wrapped around the modulator bit FIFO.
//
// Handshake: a requester bit moves into the FIFO in any cycle where
// req_valid[i] and req_ready[i] are both high; ready never waits on valid,
// and valid may drop at any time without losing the grant.
module mod_fifo_sched
  import mod_sched_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int DEPTH     = 8,
  parameter int PREFILL   = 4,
  parameter int UCNT_W    = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_bit,
  output logic [1:0]             req_ready,
  output logic [1:0]             grant,
  output logic                   fifo_wen,
  output logic                   fifo_din,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  output logic                   fifo_ren,
  input  logic                   mod_flag,
  output logic                   streaming,
  output logic [$clog2(DEPTH):0] occ,
  output logic [UCNT_W-1:0]      underrun_cnt
);

  localparam int OCC_W  = occ_w(DEPTH);
  localparam int BCNT_W = bcnt_w(FRAME_LEN);

  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(FRAME_LEN - 1);
  localparam logic [OCC_W-1:0]  OCC_MAX  = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0]  OCC_PRE  = OCC_W'(PREFILL);
  localparam logic [UCNT_W-1:0] UCNT_MAX = '1;

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic [1:0]        grant_q, grant_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [UCNT_W-1:0] ucnt_q, ucnt_d;
  logic [1:0]        arb_pick;
  logic              arb_update;
  logic              wr_ev, rd_ev;

  rr_arb2 u_arb (
    .clk    (CLK),
    .rst    (RST),
    .req    (req_valid),
    .update (arb_update),
    .winner (grant_q),
    .pick   (arb_pick)
  );

  // Write FSM: latch a frame owner, then pass its bits straight to the FIFO.
  always_comb begin
    w_state_d  = w_state_q;
    grant_d    = grant_q;
    bit_cnt_d  = bit_cnt_q;
    req_ready  = 2'b00;
    fifo_wen   = 1'b0;
    fifo_din   = 1'b0;
    arb_update = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (|req_valid) begin
          grant_d   = arb_pick;
          bit_cnt_d = '0;
          w_state_d = W_XFER;
        end
      end
      W_XFER: begin
        req_ready = grant_q & {2{~fifo_full}};
        if (|(req_valid & req_ready)) begin
          fifo_wen  = 1'b1;
          fifo_din  = |(req_bit & grant_q);
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            w_state_d  = W_IDLE;
            grant_d    = 2'b00;
            arb_update = 1'b1;
          end
        end
      end
    endcase
  end

  // Read FSM outputs: pop only on a symbol-done flag with data available.
  always_comb begin
    streaming = (r_state_q == R_RUN);
    fifo_ren  = streaming & mod_flag & ~fifo_empty;
  end

  // Read FSM next state and underrun counting.
  always_comb begin
    r_state_d = r_state_q;
    ucnt_d    = ucnt_q;
    case (r_state_q)
      R_FILL: begin
        if (occ_d >= OCC_PRE) r_state_d = R_RUN;
      end
      R_RUN: begin
        if (mod_flag && fifo_empty) begin
          r_state_d = R_FILL;
          if (ucnt_q != UCNT_MAX) ucnt_d = ucnt_q + 1'b1;
        end
      end
    endcase
  end

  // Occupancy mirrors the FIFO's own count from accepted writes and reads.
  always_comb begin
    wr_ev = fifo_wen & ~fifo_full;
    rd_ev = fifo_ren & ~fifo_empty;
    occ_d = occ_q;
    if (wr_ev && !rd_ev && (occ_q != OCC_MAX)) begin
      occ_d = occ_q + 1'b1;
    end else if (rd_ev && !wr_ev && (occ_q != '0)) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // State registers; reset abandons any frame in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_FILL;
      grant_q   <= 2'b00;
      bit_cnt_q <= '0;
      occ_q     <= '0;
      ucnt_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      grant_q   <= grant_d;
      bit_cnt_q <= bit_cnt_d;
      occ_q     <= occ_d;
      ucnt_q    <= ucnt_d;
    end
  end

  assign grant        = grant_q;
  assign occ          = occ_q;
  assign underrun_cnt = ucnt_q;

  a_occ_full: assert property (@(posedge CLK) disable iff (RST)
    (occ_q == OCC_MAX) |-> fifo_full);
  a_occ_empty: assert property (@(posedge CLK) disable iff (RST)
    (occ_q == '0) |-> fifo_empty);
  a_no_wen_full: assert property (@(posedge CLK) disable iff (RST)
    !(fifo_wen && fifo_full));
  a_no_ren_empty: assert property (@(posedge CLK) disable iff (RST)
    !(fifo_ren && fifo_empty));

endmodule
